// File: rtl/vend_pkg.sv
// vend_pkg: FSM states, coin values and coin-index encoding shared by vending_core.
package vend_pkg;
   typedef enum logic [1:0] {IDLE, PAY, DISPENSE, CHANGE} state_t;
   localparam int C5 = 2;
   localparam int C2 = 1;
   localparam int C1 = 0;
   localparam logic [2:0] V5 = 3'd5;
   localparam logic [2:0] V2 = 3'd2;
   localparam logic [2:0] V1 = 3'd1;
   // value of the highest-valued coin bit set, 0 when no bit is set
   function automatic logic [2:0] coin_val(input logic [2:0] c);
      return c[C5] ? V5 : c[C2] ? V2 : c[C1] ? V1 : 3'd0;
   endfunction
endpackage

// File: rtl/vending_core_if.sv
// vending_core_if: product/coin buttons in, dispense/change/status out.
interface vending_core_if #(
   parameter int N_PROD = 4,
   parameter int CW = 8
);
   logic [N_PROD-1:0] sel;
   logic [2:0]        coin;
   logic              cancel;
   logic [N_PROD-1:0] prod_out;
   logic [2:0]        chg_out;
   logic              coin_rej;
   logic [CW-1:0]     credit;
   logic              busy;
   modport master (output sel, coin, cancel, input prod_out, chg_out, coin_rej, credit, busy);
   modport slave (input sel, coin, cancel, output prod_out, chg_out, coin_rej, credit, busy);
endinterface

// File: rtl/vending_core_hold_timer.sv
// hold_timer: loadable down-counter; done_o pulses while enabled at zero.
module hold_timer #(
   parameter int W = 4
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         load_i,
   input  logic         en_i,
   input  logic [W-1:0] val_i,
   output logic         done_o
);
   logic [W-1:0] cnt_q, cnt_d;
   always_comb cnt_d = load_i ? val_i : (en_i && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
   always_ff @(posedge clock) cnt_q <= reset ? '0 : cnt_d;
   assign done_o = en_i && cnt_q == '0;
endmodule

// File: rtl/vending_core.sv
// vending_core: vending FSM (select, pay, dispense, greedy change) with edge-detected coins.
module vending_core
   import vend_pkg::*;
#(
   parameter int N_PROD = 4,
   parameter int CW = 8,
   parameter logic [N_PROD*CW-1:0] PRICES = {8'd7, 8'd5, 8'd3, 8'd2},
   parameter int DISP_CYC = 10,
   parameter int CHG_CYC = 9
) (
   input logic clock,
   input logic reset,
   vending_core_if.slave bus
);
   localparam int IW = $clog2(N_PROD);
   localparam int TW = $clog2((DISP_CYC > CHG_CYC ? DISP_CYC : CHG_CYC) + 1);
   state_t          state_q, state_d;
   logic [CW-1:0]   credit_q, credit_d, price_q, price_d, sum, chg_val;
   logic [CW:0]     sum_w;
   logic [IW-1:0]   idx_q, idx_d, sel_idx;
   logic [2:0]      coin_q, edges, chg;
   logic            rej_q, rej_d, sel_ok, multi, load, en, done;
   logic [TW-1:0]   load_val;
   assign edges  = bus.coin & ~coin_q;
   assign multi  = (edges & (edges - 3'd1)) != 3'd0;
   assign sel_ok = bus.sel != '0 && (bus.sel & (bus.sel - N_PROD'(1))) == '0;
   always_comb begin
      sel_idx = '0;
      for (int i = 0; i < N_PROD; i++) sel_idx = bus.sel[i] ? IW'(i) : sel_idx;
   end
   // a rejected multi-coin cycle contributes nothing; credit saturates
   assign sum_w   = {1'b0, credit_q} + (CW + 1)'(multi ? 3'd0 : coin_val(edges));
   assign sum     = sum_w[CW] ? '1 : sum_w[CW-1:0];
   assign chg     = credit_q >= CW'(V5) ? 3'b100 : credit_q >= CW'(V2) ? 3'b010 :
                    credit_q != '0 ? 3'b001 : 3'b000;
   assign chg_val = CW'(coin_val(chg));
   assign en      = state_q == DISPENSE || state_q == CHANGE;
   always_comb begin
      state_d  = state_q;
      credit_d = credit_q;
      idx_d    = idx_q;
      price_d  = price_q;
      rej_d    = edges != 3'd0;
      load     = 1'b0;
      load_val = TW'(CHG_CYC - 1);
      case (state_q)
         IDLE: if (sel_ok) begin
            idx_d   = sel_idx;
            price_d = PRICES[sel_idx*CW +: CW];
            state_d = PAY;
         end
         PAY: begin
            rej_d    = multi;
            credit_d = sum;
            if (bus.cancel) begin
               state_d = CHANGE;
               load    = 1'b1;
            end else if (credit_q >= price_q) begin
               credit_d = sum - price_q;
               state_d  = DISPENSE;
               load     = 1'b1;
               load_val = TW'(DISP_CYC - 1);
            end
         end
         DISPENSE: if (done) begin
            state_d = credit_q != '0 ? CHANGE : IDLE;
            load    = 1'b1;
         end
         CHANGE: if (credit_q == '0) state_d = IDLE;
         else if (done) begin
            credit_d = credit_q - chg_val;
            state_d  = credit_d == '0 ? IDLE : CHANGE;
            load     = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= IDLE;
         credit_q <= '0;
         idx_q    <= '0;
         price_q  <= '0;
         rej_q    <= 1'b0;
         coin_q   <= 3'd0;
      end else begin
         state_q  <= state_d;
         credit_q <= credit_d;
         idx_q    <= idx_d;
         price_q  <= price_d;
         rej_q    <= rej_d;
         coin_q   <= bus.coin;
      end
   end
   hold_timer #(.W(TW)) u_timer (
      .clock  (clock),
      .reset  (reset),
      .load_i (load),
      .en_i   (en),
      .val_i  (load_val),
      .done_o (done)
   );
   assign bus.prod_out = state_q == DISPENSE ? N_PROD'(1) << idx_q : '0;
   assign bus.chg_out  = state_q == CHANGE ? chg : 3'd0;
   assign bus.coin_rej = rej_q;
   assign bus.credit   = credit_q;
   assign bus.busy     = state_q != IDLE;
endmodule
